// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: emits a full data frame or a repeat code as a mark/space
// envelope, plus a carrier-modulated copy of it for driving an IR LED.
module nec_ir_tx #(
    parameter int UNIT_CYC    = 27000,
    parameter int CARR_PERIOD = 1263,
    parameter int CARR_HIGH   = 421,
    parameter int GAP_UNITS   = 72
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       repeat_req,
    input  logic [7:0] addr,
    input  logic [7:0] cmd,
    output logic       busy,
    output logic       done,
    output logic       ir_env,
    output logic       ir_out
);

    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int CW = (CARR_PERIOD > 1) ? $clog2(CARR_PERIOD) : 1;
    localparam int NW = $clog2((GAP_UNITS > 16) ? GAP_UNITS : 16) + 1;

    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] CARR_LAST = CW'(CARR_PERIOD - 1);
    localparam logic [CW-1:0] CARR_HI   = CW'(CARR_HIGH);
    localparam logic [NW-1:0] GAP_LAST  = NW'(GAP_UNITS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        GAP        = 3'd6
    } state_t;

    state_t        state_reg, state_next;
    logic [UW-1:0] unit_cnt_reg, unit_cnt_next;
    logic [NW-1:0] units_reg, units_next;
    logic [NW-1:0] state_last;
    logic [5:0]    bit_cnt_reg, bit_cnt_next;
    logic [31:0]   shift_reg, shift_next;
    logic          is_rep_reg, is_rep_next;
    logic [CW-1:0] carr_reg, carr_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          env_reg, env_next;
    logic          out_reg, out_next;
    logic          unit_end, state_end;
    logic [31:0]   load_word;

    // Word is sent LSB first: addr, ~addr, cmd, ~cmd.
    for (genvar gi = 0; gi < 8; gi++) begin : g_word
        assign load_word[gi]      = addr[gi];
        assign load_word[8 + gi]  = ~addr[gi];
        assign load_word[16 + gi] = cmd[gi];
        assign load_word[24 + gi] = ~cmd[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            unit_cnt_reg <= '0;
            units_reg    <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            is_rep_reg   <= 1'b0;
            carr_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            env_reg      <= 1'b0;
            out_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            unit_cnt_reg <= unit_cnt_next;
            units_reg    <= units_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            is_rep_reg   <= is_rep_next;
            carr_reg     <= carr_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            env_reg      <= env_next;
            out_reg      <= out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt_reg;
        is_rep_next   = is_rep_reg;
        unit_cnt_next = unit_cnt_reg;
        units_next    = units_reg;
        carr_next     = carr_reg;

        case (state_reg)
            LEAD_MARK:  state_last = NW'(15);
            LEAD_SPACE: state_last = is_rep_reg ? NW'(3) : NW'(7);
            BIT_SPACE:  state_last = shift_reg[0] ? NW'(2) : NW'(0);
            GAP:        state_last = GAP_LAST;
            default:    state_last = NW'(0);
        endcase

        unit_end  = (unit_cnt_reg == UNIT_LAST);
        state_end = unit_end && (units_reg == state_last);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = LEAD_MARK;
                    shift_next   = load_word;
                    bit_cnt_next = '0;
                    is_rep_next  = 1'b0;
                end else if (repeat_req) begin
                    state_next   = LEAD_MARK;
                    bit_cnt_next = '0;
                    is_rep_next  = 1'b1;
                end
            end
            LEAD_MARK:  if (state_end) state_next = LEAD_SPACE;
            LEAD_SPACE: if (state_end) state_next = is_rep_reg ? STOP_MARK : BIT_MARK;
            BIT_MARK:   if (state_end) state_next = BIT_SPACE;
            BIT_SPACE: begin
                if (state_end) begin
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = bit_cnt_reg + 6'd1;
                    state_next   = (bit_cnt_reg == 6'd31) ? STOP_MARK : BIT_MARK;
                end
            end
            STOP_MARK:  if (state_end) state_next = GAP;
            GAP:        if (state_end) state_next = IDLE;
            default:    state_next = IDLE;
        endcase

        // Every state change restarts both timing counters; a mark therefore begins with carrier high.
        if (state_next != state_reg || state_reg == IDLE) begin
            unit_cnt_next = '0;
            units_next    = '0;
        end else if (unit_end) begin
            unit_cnt_next = '0;
            units_next    = units_reg + 1'b1;
        end else begin
            unit_cnt_next = unit_cnt_reg + 1'b1;
        end

        if (state_next != state_reg || state_next == IDLE || carr_reg == CARR_LAST) begin
            carr_next = '0;
        end else begin
            carr_next = carr_reg + 1'b1;
        end
    end

    // Outputs are registered copies of the decoded next state.
    always_comb begin
        env_next  = (state_next == LEAD_MARK) || (state_next == BIT_MARK) ||
                    (state_next == STOP_MARK);
        busy_next = (state_next != IDLE);
        done_next = (state_reg == GAP) && (state_next == IDLE);
        out_next  = env_next && (carr_next < CARR_HI);
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign ir_env = env_reg;
    assign ir_out = out_reg;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Self-checking bench for nec_ir_tx: envelope run lengths are compared against an
// expected-segment scoreboard, with frame timing, done pulses and carrier phase checked alongside.
module tb_nec_ir_tx;

    localparam int UNIT     = 10;
    localparam int CP       = 4;
    localparam int CH       = 1;
    localparam int GAPU     = 4;
    localparam int DATA_LEN = (121 + GAPU) * UNIT;
    localparam int REP_LEN  = (21 + GAPU) * UNIT;
    localparam int BUDGET   = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       repeat_req = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] cmd = 8'h00;
    logic       busy, done, ir_env, ir_out;

    nec_ir_tx #(
        .UNIT_CYC(UNIT), .CARR_PERIOD(CP), .CARR_HIGH(CH), .GAP_UNITS(GAPU)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .repeat_req(repeat_req),
        .addr(addr), .cmd(cmd), .busy(busy), .done(done),
        .ir_env(ir_env), .ir_out(ir_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    seg_t exp_q[$];
    seg_t obs_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   last_busy_len = 0;
    int   cur_busy_len = 0;
    int   frames_ended = 0;
    int   done_ok = 0;
    int   done_bad = 0;
    int   carr_err = 0;
    logic in_frame = 1'b0;
    logic prev_busy = 1'b0;
    logic run_lvl = 1'b0;
    int   run_len = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: splits the envelope into runs while busy and checks carrier phase inside marks.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame     = 1'b0;
                prev_busy    = 1'b0;
                cur_busy_len = 0;
            end else begin
                if (ir_out && !ir_env) carr_err++;
                if (busy) begin
                    cur_busy_len++;
                    if (!in_frame || ir_env != run_lvl) begin
                        if (in_frame) obs_q.push_back('{run_lvl, run_len});
                        in_frame = 1'b1;
                        run_lvl  = ir_env;
                        run_len  = 0;
                    end
                    if (ir_env && (ir_out !== ((run_len % CP) < CH))) carr_err++;
                    run_len++;
                end else if (in_frame) begin
                    obs_q.push_back('{run_lvl, run_len});
                    in_frame      = 1'b0;
                    last_busy_len = cur_busy_len;
                    cur_busy_len  = 0;
                    frames_ended++;
                end
                if (done) begin
                    if (!busy && prev_busy) done_ok++;
                    else done_bad++;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] w;
        w = {~c, c, ~a, a};
        exp_q.push_back('{1'b1, 16 * UNIT});
        exp_q.push_back('{1'b0, 8 * UNIT});
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back('{1'b1, UNIT});
            exp_q.push_back('{1'b0, w[i] ? 3 * UNIT : UNIT});
        end
        exp_q.push_back('{1'b1, UNIT});
        exp_q.push_back('{1'b0, GAPU * UNIT});
    endtask

    task automatic push_repeat();
        exp_q.push_back('{1'b1, 16 * UNIT});
        exp_q.push_back('{1'b0, 4 * UNIT});
        exp_q.push_back('{1'b1, UNIT});
        exp_q.push_back('{1'b0, GAPU * UNIT});
    endtask

    task automatic wait_end(output bit timed_out);
        int f0;
        f0 = frames_ended;
        timed_out = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (frames_ended != f0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        logic [3:0] outs;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        outs = {busy, done, ir_env, ir_out};
        n_checks++;
        if (outs !== 4'b0000) $display("FAIL reset_outputs got=%b want=0000", outs);
        else n_pass++;
        bad = 0;
        repeat (100) begin
            tick();
            if ({busy, done, ir_env, ir_out} !== 4'b0000) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL idle_outputs nonzero_cycles=%0d want=0", bad);
        else n_pass++;
        $display("reset/idle: outputs=%b nonzero_cycles=%0d", outs, bad);

        addr = 8'h11;
        cmd  = 8'h22;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (299) tick();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midframe_busy got=%b want=1", busy);
        else n_pass++;
        begin
            int d0;
            d0 = done_ok + done_bad;
            rst = 1'b1;
            tick();
            outs = {busy, done, ir_env, ir_out};
            n_checks++;
            if (outs !== 4'b0000) $display("FAIL midframe_reset got=%b want=0000", outs);
            else n_pass++;
            rst = 1'b0;
            repeat (20) tick();
            n_checks++;
            if ((done_ok + done_bad) !== d0 || busy !== 1'b0)
                $display("FAIL abort_no_done dones=%0d want=%0d busy=%b", done_ok + done_bad - d0, 0, busy);
            else n_pass++;
            $display("midframe reset: outputs=%b dones_after=%0d", outs, done_ok + done_bad - d0);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_data_frame();
        bit to;
        int d0;
        seg_t e, o;
        addr = 8'h00;
        cmd  = 8'hFF;
        push_frame(addr, cmd);
        d0 = done_ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(to);
        n_checks++;
        if (to) $display("FAIL data_timeout no frame end within %0d cycles", BUDGET);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL data_segcount got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.lvl !== e.lvl || o.len !== e.len)
                $display("FAIL data_segment got=%b/%0d want=%b/%0d", o.lvl, o.len, e.lvl, e.len);
            else n_pass++;
        end
        repeat (3) tick();
        n_checks++;
        if (last_busy_len !== DATA_LEN) $display("FAIL data_busy_len got=%0d want=%0d", last_busy_len, DATA_LEN);
        else n_pass++;
        n_checks++;
        if ((done_ok - d0) !== 1 || done_bad !== 0)
            $display("FAIL data_done got=%0d bad=%0d want=1 bad=0", done_ok - d0, done_bad);
        else n_pass++;
        $display("data frame addr=%h cmd=%h: busy_len=%0d dones=%0d", addr, cmd, last_busy_len, done_ok - d0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_repeat();
        bit to;
        int d0;
        seg_t e, o;
        push_repeat();
        d0 = done_ok;
        repeat_req = 1'b1;
        tick();
        repeat_req = 1'b0;
        wait_end(to);
        n_checks++;
        if (to) $display("FAIL repeat_timeout no frame end within %0d cycles", BUDGET);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL repeat_segcount got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.lvl !== e.lvl || o.len !== e.len)
                $display("FAIL repeat_segment got=%b/%0d want=%b/%0d", o.lvl, o.len, e.lvl, e.len);
            else n_pass++;
        end
        repeat (3) tick();
        n_checks++;
        if (last_busy_len !== REP_LEN || (done_ok - d0) !== 1)
            $display("FAIL repeat_len got=%0d dones=%0d want=%0d dones=1", last_busy_len, done_ok - d0, REP_LEN);
        else n_pass++;
        $display("repeat code: busy_len=%0d dones=%0d", last_busy_len, done_ok - d0);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_loopback();
        bit to;
        int k;
        logic [31:0] dec;
        seg_t e, o;
        addr = 8'h5A;
        cmd  = 8'h3C;
        push_frame(addr, cmd);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(to);
        n_checks++;
        if (to) $display("FAIL loop_timeout no frame end within %0d cycles", BUDGET);
        else n_pass++;
        dec = '0;
        k = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.lvl !== e.lvl || o.len !== e.len)
                $display("FAIL loop_segment got=%b/%0d want=%b/%0d", o.lvl, o.len, e.lvl, e.len);
            else n_pass++;
            if (k >= 3 && k <= 65 && (k % 2) == 1) dec[(k - 3) / 2] = (o.len > 2 * UNIT);
            k++;
        end
        n_checks++;
        if (dec[7:0] !== 8'h5A) $display("FAIL loop_addr got=%h want=5a", dec[7:0]);
        else n_pass++;
        n_checks++;
        if (dec[15:8] !== 8'hA5) $display("FAIL loop_naddr got=%h want=a5", dec[15:8]);
        else n_pass++;
        n_checks++;
        if (dec[23:16] !== 8'h3C) $display("FAIL loop_cmd got=%h want=3c", dec[23:16]);
        else n_pass++;
        n_checks++;
        if (dec[31:24] !== 8'hC3) $display("FAIL loop_ncmd got=%h want=c3", dec[31:24]);
        else n_pass++;
        n_checks++;
        if (carr_err !== 0) $display("FAIL carrier_phase errors=%0d want=0", carr_err);
        else n_pass++;
        $display("loopback: decoded %h %h %h %h carrier_errors=%0d", dec[7:0], dec[15:8], dec[23:16], dec[31:24], carr_err);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_priority();
        bit to;
        int d0, idle_busy;
        seg_t e, o;
        addr = 8'hA7;
        cmd  = 8'h01;
        push_frame(addr, cmd);
        d0 = done_ok;
        start = 1'b1;
        repeat_req = 1'b1;
        tick();
        start = 1'b0;
        repeat_req = 1'b0;
        repeat (498) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_end(to);
        n_checks++;
        if (to) $display("FAIL prio_timeout no frame end within %0d cycles", BUDGET);
        else n_pass++;
        n_checks++;
        if (obs_q.size() !== exp_q.size()) $display("FAIL prio_segcount got=%0d want=%0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.lvl !== e.lvl || o.len !== e.len)
                $display("FAIL prio_segment got=%b/%0d want=%b/%0d", o.lvl, o.len, e.lvl, e.len);
            else n_pass++;
        end
        idle_busy = 0;
        repeat (30) begin
            tick();
            if (busy !== 1'b0) idle_busy++;
        end
        n_checks++;
        if (last_busy_len !== DATA_LEN || (done_ok - d0) !== 1 || idle_busy !== 0)
            $display("FAIL prio_ignore busy_len=%0d dones=%0d busy_after=%0d want=%0d/1/0",
                     last_busy_len, done_ok - d0, idle_busy, DATA_LEN);
        else n_pass++;
        $display("start+repeat: busy_len=%0d dones=%0d busy_after=%0d", last_busy_len, done_ok - d0, idle_busy);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        bit to, to2;
        int dcyc[$];
        addr = 8'h81;
        cmd  = 8'h42;
        to = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (done === 1'b1) begin
                dcyc.push_back(cyc);
                tick();
                n_checks++;
                if (busy !== 1'b1) $display("FAIL b2b_restart busy=%b want=1", busy);
                else n_pass++;
                if (dcyc.size() == 3) begin
                    to = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        n_checks++;
        if (to) $display("FAIL b2b_timeout saw %0d done pulses want 3", dcyc.size());
        else n_pass++;
        if (dcyc.size() == 3) begin
            n_checks++;
            if (dcyc[1] - dcyc[0] !== DATA_LEN + 1) $display("FAIL b2b_period1 got=%0d want=%0d", dcyc[1] - dcyc[0], DATA_LEN + 1);
            else n_pass++;
            n_checks++;
            if (dcyc[2] - dcyc[1] !== DATA_LEN + 1) $display("FAIL b2b_period2 got=%0d want=%0d", dcyc[2] - dcyc[1], DATA_LEN + 1);
            else n_pass++;
            $display("back-to-back: periods %0d %0d", dcyc[1] - dcyc[0], dcyc[2] - dcyc[1]);
        end
        wait_end(to2);
        repeat (3) tick();
        n_checks++;
        if (to2 || done_bad !== 0 || last_busy_len !== DATA_LEN)
            $display("FAIL b2b_tail timeout=%0d bad_dones=%0d busy_len=%0d want=0/0/%0d", to2, done_bad, last_busy_len, DATA_LEN);
        else n_pass++;
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_data_frame();
        test_repeat();
        test_loopback();
        test_priority();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nec_ir_tx.md
Name: nec_ir_tx

Overview:
- NEC-protocol infrared transmitter; the transmit-side counterpart of the board's IR receive path.
- Takes an 8-bit address and an 8-bit command and emits a complete NEC frame: 9 ms leader, 4.5 ms space, 32 data bits, stop mark.
- Can also emit the NEC repeat code.
- Output is carrier-modulated, for driving an IR LED from the 48 MHz system clock.
- Also provides the unmodulated envelope, for loopback into the receiver.

Parameters:
- UNIT_CYC, 27000, clk cycles per 562.5 us NEC time unit (48 MHz).
- CARR_PERIOD, 1263, clk cycles per carrier period (about 38 kHz).
- CARR_HIGH, 421, carrier high cycles per period (about 1/3 duty); must be less than CARR_PERIOD.
- GAP_UNITS, 72, trailing idle units after the stop mark before busy drops (40.5 ms).

Ports:
- clk  in  1  system clock (48 MHz).
- rst  in  1  synchronous reset, active-high.
- start  in  1  request data frame; sampled only while busy=0.
- repeat_req  in  1  request repeat code; sampled only while busy=0.
- addr  in  8  address byte; latched when start is accepted.
- cmd  in  8  command byte; latched when start is accepted.
- busy  out  1  frame in progress, including the trailing gap.
- done  out  1  one-cycle pulse at frame completion.
- ir_env  out  1  unmodulated mark envelope (1 = mark).
- ir_out  out  1  modulated LED drive, equal to ir_env AND carrier.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE; busy, done, ir_env, ir_out, all counters and latches are 0 after that edge.
  - Applies mid-frame: the frame aborts immediately and no done pulse is produced.
- Acceptance (in IDLE, at a clk edge):
  - start=1 accepts a data frame; repeat_req=1 accepts a repeat.
  - If both are 1, start wins.
  - Requests while busy=1 are ignored; they are not queued.
- Data latch: on acceptance, shift word = {~cmd, cmd, ~addr, addr}. Transmission is LSB first, so addr bit0 goes first.
- Latency: busy=1 and ir_env=1 on the cycle after the accepting edge.
- Unit counter: counts 0..UNIT_CYC-1; each state lasts an exact integer number of units.
- States and durations:
  - LEAD_MARK: 16 units, env=1.
  - LEAD_SPACE: 8 units for a data frame, 4 units for a repeat; env=0.
  - BIT_MARK: 1 unit, env=1.
  - BIT_SPACE: 1 unit if the current bit is 0, 3 units if it is 1; env=0.
  - STOP_MARK: 1 unit, env=1.
  - GAP: GAP_UNITS units, env=0.
  - Then IDLE.
- Transitions:
  - Data frame: LEAD_MARK → LEAD_SPACE → (BIT_MARK → BIT_SPACE) ×32 via a 6-bit bit counter → STOP_MARK → GAP → IDLE.
  - Repeat: LEAD_MARK → LEAD_SPACE → STOP_MARK → GAP → IDLE.
- Frame length: every data frame has 16 ones and 16 zeros, so total length is 121+GAP_UNITS units. A repeat is 21+GAP_UNITS units.
- Completion: done=1 for exactly one cycle, on the first cycle with busy=0. A start on that same cycle is accepted (back-to-back frames allowed).
- Carrier:
  - Counter runs 0..CARR_PERIOD-1; carrier=1 while count < CARR_HIGH.
  - The counter restarts at 0 on entry to every mark state, so each mark begins with carrier high.
  - ir_out is 0 whenever ir_env=0.
- Register width: all outputs are registered; no combinational path from any input to any output.

Test Plan:
Bench parameters for all scenarios: UNIT_CYC=10, CARR_PERIOD=4, CARR_HIGH=1, GAP_UNITS=4.
- Reset then idle → busy, done, ir_env, ir_out all 0 for 100 cycles; assert rst mid-frame at cycle 300 → all outputs 0 on the next cycle, no done.
- start pulse with addr=0x00, cmd=0xFF → envelope decodes as:
  - 160-cycle mark, 80-cycle space;
  - addr and ~cmd fields: eight (10 mark, 10 space) each;
  - ~addr and cmd fields: eight (10 mark, 30 space) each;
  - 10-cycle stop mark.
  busy lasts exactly 1250 cycles, then done is pulsed once.
- repeat_req pulse → 160-cycle mark, 40-cycle space, 10-cycle stop mark, 40-cycle gap; busy lasts exactly 250 cycles.
- addr=0x5A, cmd=0x3C, with a loopback decoder on ir_env → decoded bytes 0x5A, 0xA5, 0x3C, 0xC3; during marks ir_out follows the pattern 1,0,0,0 repeated, starting with 1.
- start and repeat_req asserted in the same cycle → data frame of 1250 cycles is sent; a start pulse at cycle 500 of that frame is ignored (exactly one done pulse).
- start held high continuously → consecutive frames; each done cycle is immediately followed by busy=1, and the frame period is exactly 1251 cycles.
